// File: rtl/fpga_cfg_loader_pkg.sv
// Shared definitions for the configuration-chain loader: loader states and byte width.
package fpga_cfg_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    CFG_IDLE,
    CFG_FETCH,
    CFG_SHIFT_LO,
    CFG_SHIFT_HI,
    CFG_DONE
  } cfg_state_e;

endpackage

// File: rtl/cfg_phase_timer.sv
// DIV-cycle down counter: after a load, expire rises on the DIV-th cycle of the phase.
module cfg_phase_timer #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic expire
);

  localparam int DIV_W = $clog2(DIV + 1);

  logic [DIV_W-1:0] cnt;

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= DIV_W'(DIV - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/fpga_cfg_loader.sv
// Serializes a byte stream MSB-first onto the fabric config chain, driving prog_clk and
// holding the fabric in reset until exactly CHAIN_LEN bits have been shifted.
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 1024,
  parameter int DIV       = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [BYTE_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              prog_clk,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              fabric_reset,
  output logic              busy,
  output logic              done,
  output logic              tail_parity
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);

  cfg_state_e        state;
  logic [CNT_W-1:0]  bits_left;
  logic [2:0]        bit_idx;
  logic [BYTE_W-2:0] byte_rest;
  logic              transfer;
  logic              phase_load;
  logic              phase_expire;

  assign transfer = cfg_valid && cfg_ready;

  // Reloading outside the shift phases means each phase starts with a full DIV dwell.
  assign phase_load = !(state == CFG_SHIFT_LO || state == CFG_SHIFT_HI) || phase_expire;

  cfg_phase_timer #(.DIV(DIV)) u_phase_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (phase_load),
    .expire (phase_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CFG_IDLE;
      bits_left    <= '0;
      bit_idx      <= '0;
      byte_rest    <= '0;
      cfg_ready    <= 1'b0;
      prog_clk     <= 1'b0;
      ccff_head    <= 1'b0;
      fabric_reset <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      tail_parity  <= 1'b0;
    end else if (abort) begin
      state        <= CFG_IDLE;
      cfg_ready    <= 1'b0;
      prog_clk     <= 1'b0;
      fabric_reset <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      unique case (state)
        CFG_IDLE, CFG_DONE: begin
          if (start) begin
            state        <= CFG_FETCH;
            bits_left    <= CNT_W'(CHAIN_LEN);
            tail_parity  <= 1'b0;
            fabric_reset <= 1'b1;
            done         <= 1'b0;
            busy         <= 1'b1;
            cfg_ready    <= 1'b1;
          end
        end
        CFG_FETCH: begin
          if (transfer) begin
            state     <= CFG_SHIFT_LO;
            ccff_head <= cfg_data[BYTE_W-1];
            byte_rest <= cfg_data[BYTE_W-2:0];
            bit_idx   <= 3'd7;
            cfg_ready <= 1'b0;
          end
        end
        CFG_SHIFT_LO: begin
          // Tail is sampled before the rising edge so it reflects the old chain bit.
          if (phase_expire) begin
            state       <= CFG_SHIFT_HI;
            tail_parity <= tail_parity ^ ccff_tail;
            prog_clk    <= 1'b1;
          end
        end
        CFG_SHIFT_HI: begin
          if (phase_expire) begin
            prog_clk  <= 1'b0;
            bits_left <= bits_left - CNT_W'(1);
            if (bits_left == CNT_W'(1)) begin
              state        <= CFG_DONE;
              busy         <= 1'b0;
              done         <= 1'b1;
              fabric_reset <= 1'b0;
            end else if (bit_idx == 3'd0) begin
              state     <= CFG_FETCH;
              cfg_ready <= 1'b1;
            end else begin
              state     <= CFG_SHIFT_LO;
              bit_idx   <= bit_idx - 3'd1;
              ccff_head <= byte_rest[BYTE_W-2];
              byte_rest <= {byte_rest[BYTE_W-3:0], 1'b0};
            end
          end
        end
        default: state <= CFG_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Scoreboard bench: expected chain bits are queued as bytes are offered and popped on prog_clk rises.
module tb_fpga_cfg_loader;

  localparam int CL = 12;

  logic       clk = 1'b0;
  logic       reset, start, abort, cfg_valid;
  logic [7:0] cfg_data;
  logic       cfg_ready, prog_clk, ccff_head, ccff_tail;
  logic       fabric_reset, busy, done, tail_parity;

  logic       reset3, start3, abort3, cfg_valid3, ccff_tail3;
  logic [7:0] cfg_data3;
  logic       cfg_ready3, prog_clk3, ccff_head3;
  logic       fabric_reset3, busy3, done3, tail_parity3;

  logic [CL-1:0] chain;
  logic [7:0]    src_q[$];
  bit            exp_q[$];
  int n_cmp = 0, n_err = 0;
  int bytes_taken, extra_edges, stall_bad, fetch_waits, stall, rises, cyc;
  int rises3, run3;
  bit stall_en, pc_prev, pc3_prev, pc3_track;
  bit exp_parity;

  assign ccff_tail = chain[CL-1];

  always #5 clk = ~clk;

  fpga_cfg_loader #(.CHAIN_LEN(CL), .DIV(1)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .fabric_reset(fabric_reset), .busy(busy), .done(done), .tail_parity(tail_parity)
  );

  fpga_cfg_loader #(.CHAIN_LEN(CL), .DIV(3)) dut3 (
    .clk(clk), .reset(reset3), .start(start3), .abort(abort3),
    .cfg_data(cfg_data3), .cfg_valid(cfg_valid3), .cfg_ready(cfg_ready3),
    .prog_clk(prog_clk3), .ccff_head(ccff_head3), .ccff_tail(ccff_tail3),
    .fabric_reset(fabric_reset3), .busy(busy3), .done(done3), .tail_parity(tail_parity3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: byte-source driver, chain model and both prog_clk monitors.
  task automatic tick();
    logic xfer;
    xfer = cfg_valid && cfg_ready && !abort && !reset;
    @(negedge clk);
    cyc++;
    if (xfer) begin
      void'(src_q.pop_front());
      bytes_taken++;
      if (stall_en && bytes_taken == 1) stall = 5;
    end
    if (prog_clk && !pc_prev) begin
      rises++;
      exp_parity ^= chain[CL-1];
      if (exp_q.size() == 0) extra_edges++;
      else check("head_bit", ccff_head, exp_q.pop_front());
      chain = {chain[CL-2:0], ccff_head};
    end
    pc_prev = prog_clk;
    if (cfg_ready && prog_clk) stall_bad++;
    if (stall > 0 && cfg_ready) begin
      stall--;
      fetch_waits++;
      cfg_valid = 1'b0;
    end else begin
      cfg_valid = (src_q.size() > 0);
    end
    cfg_data = (src_q.size() > 0) ? src_q[0] : 8'h00;

    if (prog_clk3 != pc3_prev) begin
      if (prog_clk3) rises3++;
      if (pc3_track) begin
        if (!prog_clk3) check("hi_time", run3, 3);
        else if (rises3 >= 2 && rises3 <= 8) check("lo_time", run3, 3);
      end
      run3 = 1;
    end else begin
      run3++;
    end
    pc3_prev = prog_clk3;
  endtask

  task automatic queue_load(input logic [15:0] bytes2, input logic [CL-1:0] preload);
    src_q.delete();
    exp_q.delete();
    bytes_taken = 0; extra_edges = 0; stall_bad = 0; fetch_waits = 0; rises = 0;
    chain = preload;
    src_q.push_back(bytes2[15:8]);
    src_q.push_back(bytes2[7:0]);
    for (int i = 0; i < CL; i++) exp_q.push_back(bytes2[15-i]);
    cfg_valid = 1'b1;
    cfg_data  = src_q[0];
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    exp_parity = 1'b0;
    cyc = 0;
  endtask

  task automatic run_to_done(input string tag, input int lat);
    for (int i = 0; i < 300 && !done; i++) tick();
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_fabric_reset"}, fabric_reset, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_bytes"}, bytes_taken, 2);
    check({tag, "_bits_left"}, exp_q.size(), 0);
    check({tag, "_parity"}, tail_parity, exp_parity);
  endtask

  task automatic wait_rises(input int n);
    for (int i = 0; i < 200 && rises < n; i++) tick();
    check("rise_wait", rises, n);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    reset3 = 1'b1; start3 = 1'b0; abort3 = 1'b0; cfg_valid3 = 1'b1; cfg_data3 = 8'hA5;
    ccff_tail3 = 1'b1; chain = '0; stall_en = 1'b0; stall = 0;
    pc3_track = 1'b0; rises3 = 0; run3 = 0;
    repeat (3) tick();
    check("reset_outs", {prog_clk, ccff_head, cfg_ready, busy, done, fabric_reset, tail_parity}, 7'b0000010);
    reset = 1'b0;
    reset3 = 1'b0;
    tick();
    check("idle_outs", {prog_clk, cfg_ready, busy, done, fabric_reset}, 5'b00001);

    // Basic load into an all-ones chain, then done must stay sticky.
    queue_load(16'hA5C0, 12'hFFF);
    start_pulse();
    run_to_done("t1", 2 * CL + 2);
    check("t1_chain", chain, 12'hA5C);
    check("t1_extra_edges", extra_edges, 0);
    repeat (3) tick();
    check("t1_sticky", {done, fabric_reset, prog_clk, cfg_ready}, 4'b1000);

    // Restart from DONE with a different old chain content.
    queue_load(16'hA5C0, 12'h001);
    start_pulse();
    run_to_done("t2", 2 * CL + 2);

    // Five-cycle stall before the second byte.
    queue_load(16'hA5C0, 12'h5A3);
    stall_en = 1'b1;
    start_pulse();
    run_to_done("t3", 2 * CL + 2 + 5);
    stall_en = 1'b0;
    check("t3_waits", fetch_waits, 5);
    check("t3_no_clk_in_fetch", stall_bad, 0);
    check("t3_chain", chain, 12'hA5C);

    // Abort after the fifth bit, then a full reload.
    queue_load(16'hA5C0, 12'h0F0);
    start_pulse();
    wait_rises(5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_outs", {busy, done, fabric_reset, cfg_ready, prog_clk}, 5'b00100);
    check("t4_parity_kept", tail_parity, exp_parity);
    exp_q.delete();
    src_q.delete();
    repeat (10) tick();
    check("t4_no_edges", extra_edges, 0);
    check("t4_still_idle", {busy, cfg_ready}, 2'b00);
    queue_load(16'h3C90, 12'h123);
    start_pulse();
    run_to_done("t4_reload", 2 * CL + 2);
    check("t4_chain", chain, 12'h3C9);

    // start while busy is ignored; start+abort together from DONE goes to IDLE.
    queue_load(16'h5A30, 12'hABC);
    start_pulse();
    wait_rises(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    run_to_done("t6", 2 * CL + 2);
    check("t6_chain", chain, 12'h5A3);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t6_start_abort", {busy, done, fabric_reset, cfg_ready, prog_clk}, 5'b00100);
    check("t6_parity_kept", tail_parity, exp_parity);
    repeat (4) tick();
    check("t6_no_fetch", cfg_ready, 0);

    // DIV=3 dwell times, then reset in the middle of a high phase.
    pc3_track = 1'b1;
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int i = 0; i < 300 && rises3 < 11; i++) tick();
    check("t5_rises", rises3, 11);
    check("t5_pre_reset_hi", {prog_clk3, ccff_head3, tail_parity3}, 3'b111);
    pc3_track = 1'b0;
    reset3 = 1'b1;
    tick();
    check("t5_reset_outs",
          {prog_clk3, ccff_head3, cfg_ready3, busy3, done3, fabric_reset3, tail_parity3}, 7'b0000010);
    reset3 = 1'b0;
    tick();
    check("t5_idle_after_reset", {prog_clk3, busy3}, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
